// File: rtl/rr_hold_scheduler_if.sv
// Request/done inputs and registered grant outputs of the hold-based round-robin scheduler.
interface rr_hold_scheduler_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          timeout;

  modport master (output req, done, input grant, grant_valid, grant_idx, timeout);
  modport slave  (input req, done, output grant, grant_valid, grant_idx, timeout);
endinterface

// File: rtl/rr_hold_scheduler.sv
// Round-robin owner of a shared resource; grant registered one cycle after req, held until done/req drop/timeout.
// No backpressure: requesters simply keep req high; at least one idle cycle separates grants.
module rr_hold_scheduler #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rstn,
  rr_hold_scheduler_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic          timeout_q, timeout_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          own_done, own_req, hold_end, rel;
  logic [IW-1:0] next_ptr;

  // Masked pass (index >= ptr) first, then a wrap-around pass over all requests.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && bus.req[i] && (i >= int'(ptr_q))) begin
        win_idx   = IW'(i);
        win_found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!win_found && bus.req[i]) begin
        win_idx   = IW'(i);
        win_found = 1'b1;
      end
    end
  end

  assign own_done = bus.done[grant_idx_q];
  assign own_req  = bus.req[grant_idx_q];
  assign hold_end = (cnt_q == CW'(MAX_HOLD - 1));
  assign rel      = own_done | ~own_req | hold_end;
  assign next_ptr = (grant_idx_q == IW'(N - 1)) ? '0 : grant_idx_q + IW'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d       = OWNED;
          grant_d       = {{(N-1){1'b0}}, 1'b1} << win_idx;
          grant_valid_d = 1'b1;
          grant_idx_d   = win_idx;
          cnt_d         = '0;
        end
      end
      OWNED: begin
        if (rel) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          ptr_d         = next_ptr;
          cnt_d         = '0;
          // A cooperative release in the last allowed cycle is not a timeout.
          timeout_d     = hold_end & ~own_done & own_req;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: doc/rr_hold_scheduler.md
# rr_hold_scheduler

Round-robin scheduler that shares one single-owner resource among N requesters and holds ownership for a whole transaction, not a single cycle. A grant is issued registered and one-hot. It stays stable until one of three things happens: the owner signals `done`, the owner drops `req`, or a hold timeout expires. The rotating priority pointer then advances past the released owner. It sits between requesting masters and the shared datapath as that datapath's access controller.

## Interface
- `N`, default 4: number of requesters; N ≥ 2.
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant; MAX_HOLD ≥ 1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `req` input N: per-requester request level; held high while the requester wants or uses the resource.
- `done` input N: per-requester end-of-transaction strobe; only the owner's bit is honoured.
- `grant` output N: registered one-hot ownership; all-zero when idle.
- `grant_valid` output 1: registered; high exactly when `grant` is non-zero.
- `grant_idx` output $clog2(N): registered index of the current owner; 0 when idle.
- `timeout` output 1: registered one-cycle pulse, high in the first cycle after a timeout-forced release.

## Operation
- State machine has two states:
  - IDLE: `grant` = 0.
  - OWNED: exactly one `grant` bit set.
- Priority pointer `ptr`, width $clog2(N), resets to 0.
- Selection is evaluated combinationally in IDLE:
  - Masked set = `req` bits with index ≥ `ptr`.
  - If the masked set is non-zero, the lowest set index in it wins.
  - Otherwise the lowest set index of the unmasked `req` wins (wrap-around).
- IDLE → OWNED when `|req` = 1 at a rising edge.
  - `grant`, `grant_idx` and `grant_valid` load the winner.
  - Hold counter `cnt` loads 0.
- IDLE → IDLE when `req` = 0; `ptr` is unchanged.
- In OWNED, at each edge, with `o` = owner index:
  - Release if `done[o]` = 1, or `req[o]` = 0, or `cnt` = MAX_HOLD−1.
  - On release: go to IDLE, clear `grant`, `grant_valid` and `grant_idx`, and set `ptr` ← (o+1) mod N. The wrap arithmetic must be correct when N is not a power of two.
  - `timeout` ← 1 only when `cnt` = MAX_HOLD−1 and neither `done[o]` nor the `req[o]` drop is present. Otherwise `timeout` ← 0.
  - If there is no release, `cnt` ← `cnt`+1.
- `cnt` width is $clog2(MAX_HOLD+1). It never exceeds MAX_HOLD−1.
- `done` bits and `req` changes of non-owners are ignored while OWNED. New requests do not preempt the owner.
- Simultaneous `done[o]` and timeout condition: counts as a normal release, `timeout` = 0.
- Owner re-requesting at its own release is still subject to rotation: it wins again only if no other requester is active.
- MAX_HOLD = 1: every grant lasts exactly one cycle. `timeout` pulses unless `done[o]` is high or `req[o]` is low in that cycle.

## Timing
- Reset: asynchronous assertion forces the following immediately, regardless of state or mid-transaction:
  - State = IDLE.
  - `grant` = 0, `grant_valid` = 0, `grant_idx` = 0, `timeout` = 0.
  - `ptr` = 0, `cnt` = 0.
- Deassertion: first possible grant appears after the first rising edge with `rstn` high and `req` non-zero.
- Grant latency: `req` high before edge k while IDLE → `grant` visible after edge k.
- Release latency: `done[o]` high before edge k → `grant` = 0 after edge k.
- Mandatory idle gap: minimum one cycle with `grant` = 0 between consecutive grants, including back-to-back ownership by the same requester.
- Maximum ownership: MAX_HOLD cycles of `grant` high; `timeout` high in the following (idle) cycle only.
- Worst-case wait for a continuously requesting master: (N−1)·(MAX_HOLD+1) cycles from first edge with `req` high until its grant.
- `done` is a single-cycle strobe by contract. A `done` that stays high past its release is ignored in IDLE.

## Test plan
- **Reset and basic grant.** Hold `rstn`=0, then release with `req`=4'b0100. Required: `grant`=0 during reset; `grant`=4'b0100 and `grant_idx`=2 after the first edge; `ptr`=3 after `done[2]`.
- **Rotation under full load.** Keep `req`=4'b1111 and pulse the owner's `done` 1 cycle after each grant. Required: grant order 0,1,2,3,0, with exactly one idle cycle between grants.
- **Timeout.** MAX_HOLD=16, `req`=4'b0010, never pulse `done`. Required: `grant`=4'b0010 for exactly 16 cycles, then 0; `timeout`=1 for exactly 1 cycle; regrant to requester 1 one cycle later.
- **Wrap and non-owner noise.** Set `ptr`=3 via a prior grant to 2, then `req`=4'b0011 with `done`=4'b0010 while 0 owns. Required: requester 0 wins; the `done[1]` strobe does not release it.
- **Simultaneous done and timeout, and request drop.** Assert `done[o]` at `cnt`=MAX_HOLD−1. Required: release with `timeout`=0. Separately, drop `req[o]` mid-hold. Required: release on that edge.
- **Reset mid-ownership.** Pull `rstn` low between edges while `grant`=4'b1000. Required: all outputs 0 immediately without waiting for an edge; the next grant after reset follows `ptr`=0 priority.
